amber_wb_slave_responder: RTL

// - Synthesizable Wishbone slave that answers the Amber core's 128-bit Wishbone master
//   (instruction and data fetch), replacing ad-hoc i_wb_dat/i_wb_ack driving.
// - Line-organised memory with preload port, programmable wait states, byte-lane merge,
//   and a capture FIFO of every committed write for the result monitor.

---
 rtl/amber_wb_resp_pkg.sv | 21 ++
 rtl/amber_wb_resp_cap_fifo.sv | 62 ++++++
 rtl/amber_wb_slave_responder.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/amber_wb_resp_pkg.sv
// Shared types for the Amber Wishbone slave responder: FSM states, the
// capture-FIFO entry layout and the never-written-line fill helper.
package amber_wb_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } resp_state_e;

  typedef struct packed {
    logic [31:0]  adr;
    logic [15:0]  sel;
    logic [127:0] dat;
  } cap_entry_t;

  function automatic logic [127:0] fill_line(input logic [31:0] fill_word);
    return {4{fill_word}};
  endfunction

endpackage

// File: rtl/amber_wb_resp_cap_fifo.sv
// Synchronous FIFO holding every committed bus write for the result monitor.
// Push while full and pop while empty are both ignored.
module amber_wb_resp_cap_fifo
  import amber_wb_resp_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  cap_entry_t    din,
  input  logic          pop,
  output cap_entry_t    dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  cap_entry_t    store [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage carries no reset; only the pointers define what is live.
  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr_q] <= din;
  end

  assign dout  = store[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/amber_wb_slave_responder.sv
// Wishbone slave answering the Amber 128-bit master from a line memory with
// wait states, byte merge and write capture. WB_RESP_ERR_EN enables address-window errors.
module amber_wb_slave_responder
  import amber_wb_resp_pkg::*;
#(
  parameter int          AW          = 10,
  parameter logic [31:0] BASE_ADR    = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 0,
  parameter int          CAP_DEPTH   = 8,
  parameter logic [31:0] FILL_WORD   = 32'hF0801003
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [31:0]                  i_wb_adr,
  input  logic [15:0]                  i_wb_sel,
  input  logic                         i_wb_we,
  input  logic [127:0]                 i_wb_dat,
  input  logic                         i_wb_cyc,
  input  logic                         i_wb_stb,
  output logic [127:0]                 o_wb_dat,
  output logic                         o_wb_ack,
  output logic                         o_wb_err,
  input  logic                         i_ld_en,
  input  logic [AW-1:0]                i_ld_idx,
  input  logic [127:0]                 i_ld_dat,
  output logic                         o_cap_valid,
  input  logic                         i_cap_pop,
  output logic [31:0]                  o_cap_adr,
  output logic [15:0]                  o_cap_sel,
  output logic [127:0]                 o_cap_dat,
  output logic [$clog2(CAP_DEPTH):0]   o_cap_count
);

  localparam int         LINES     = 2 ** AW;
  localparam int         CW        = $clog2(CAP_DEPTH) + 1;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  resp_state_e    state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [31:0]    adr_q, adr_d;
  logic [15:0]    sel_q, sel_d;
  logic           we_q, we_d;
  logic [127:0]   wdat_q, wdat_d;
  logic           ack_q, ack_d;
  logic           err_q, err_d;
  logic [127:0]   rdat_q, rdat_d;
  logic [LINES-1:0] valid_q, valid_d;

  logic [127:0]   mem [LINES];
  logic [AW-1:0]  req_idx;
  logic [127:0]   line_old;
  logic [127:0]   line_base;
  logic [127:0]   merged;
  logic           addr_err;
  logic           commit;
  logic           cap_full;
  logic           cap_empty;
  cap_entry_t     cap_in;
  cap_entry_t     cap_out;
  logic           unused_base;

  assign req_idx = adr_q[AW+3:4];

`ifdef WB_RESP_ERR_EN
  assign addr_err = (adr_q[31:AW+4] != BASE_ADR[31:AW+4]);
`else
  assign addr_err = 1'b0;
`endif
  assign unused_base = ^BASE_ADR;

  // A preload hitting the committing line lands first; bus bytes then overlay it.
  assign line_old  = valid_q[req_idx] ? mem[req_idx] : fill_line(FILL_WORD);
  assign line_base = (i_ld_en && (i_ld_idx == req_idx)) ? i_ld_dat : line_old;

  always_comb begin
    merged = line_base;
    for (int b = 0; b < 16; b++) begin
      if (sel_q[b]) merged[8*b +: 8] = wdat_q[8*b +: 8];
    end
  end

  assign commit = (state_q == RESP) && we_q && !addr_err;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    sel_d   = sel_q;
    we_d    = we_q;
    wdat_d  = wdat_q;
    rdat_d  = rdat_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: begin
        if (i_wb_cyc && i_wb_stb) begin
          adr_d   = i_wb_adr;
          sel_d   = i_wb_sel;
          we_d    = i_wb_we;
          wdat_d  = i_wb_dat;
          cnt_d   = WAIT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!i_wb_cyc) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          // Full is the registered flag, so a same-cycle pop does not unblock the write.
          if (!we_q || addr_err || !cap_full) state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
        if (addr_err) begin
          err_d  = 1'b1;
          rdat_d = '0;
        end else begin
          ack_d = 1'b1;
          if (!we_q) rdat_d = line_old;
        end
      end
      default: state_d = IDLE;
    endcase
    if (i_ld_en) valid_d[i_ld_idx] = 1'b1;
    if (commit)  valid_d[req_idx]  = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      adr_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      wdat_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdat_q  <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      wdat_q  <= wdat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdat_q  <= rdat_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (i_ld_en) mem[i_ld_idx] <= i_ld_dat;
    if (commit)  mem[req_idx]  <= merged;
  end

  // Capture handshake: head is valid while o_cap_valid; it is consumed on any
  // cycle where i_cap_pop is high together with o_cap_valid.
  assign cap_in = '{adr: adr_q, sel: sel_q, dat: wdat_q};

  amber_wb_resp_cap_fifo #(
    .DEPTH (CAP_DEPTH),
    .CW    (CW)
  ) u_cap_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (commit),
    .din   (cap_in),
    .pop   (i_cap_pop),
    .dout  (cap_out),
    .full  (cap_full),
    .empty (cap_empty),
    .count (o_cap_count)
  );

  assign o_wb_dat    = rdat_q;
  assign o_wb_ack    = ack_q;
  assign o_wb_err    = err_q;
  assign o_cap_valid = !cap_empty;
  assign o_cap_adr   = cap_out.adr;
  assign o_cap_sel   = cap_out.sel;
  assign o_cap_dat   = cap_out.dat;

endmodule
